// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared latency classes, stage ages and width helpers for the hazard scoreboard
package hazard_pkg;

   typedef enum logic [1:0] {
      LAT_ALU  = 2'd0,
      LAT_LOAD = 2'd1,
      LAT_MUL  = 2'd2,
      LAT_RSVD = 2'd3
   } lat_cls_e;

   // age 0 means "read the register file", age 1 is the EX stage
   localparam int AGE_RF = 0;
   localparam int AGE_EX = 1;

   // bits needed to hold the values 0..n, never less than one
   function automatic int bits_for(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

   // width of one per-source fwd_sel field
   function automatic int fwd_w(input int num_fwd);
      return bits_for(num_fwd);
   endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// rtl/hazard_scoreboard_if.sv - ID-stage issue request and hazard response bundle
interface hazard_scoreboard_if #(
   parameter int NUM_SRC = 2,
   parameter int NUM_FWD = 4
);
   import hazard_pkg::*;

   localparam int FW = fwd_w(NUM_FWD);

   logic                   id_valid;
   logic [5*NUM_SRC-1:0]   id_src;
   logic [4:0]             id_rd;
   logic                   id_rfwr;
   logic [1:0]             id_lat_cls;
   logic                   id_hilo_wr;
   logic                   id_hilo_rd;
   logic                   hold;
   logic                   flush;
   logic                   stall;
   logic [NUM_SRC*FW-1:0]  fwd_sel;
   logic                   hilo_busy;

   modport master (
      output id_valid, id_src, id_rd, id_rfwr, id_lat_cls, id_hilo_wr, id_hilo_rd, hold, flush,
      input  stall, fwd_sel, hilo_busy
   );

   modport slave (
      input  id_valid, id_src, id_rd, id_rfwr, id_lat_cls, id_hilo_wr, id_hilo_rd, hold, flush,
      output stall, fwd_sel, hilo_busy
   );

endinterface

// File: rtl/sb_entry.sv
// rtl/sb_entry.sv - one register's in-flight producer: valid, pipeline age and result countdown
module sb_entry
   import hazard_pkg::*;
#(
   parameter int NUM_FWD     = 4,
   parameter int FLUSH_DEPTH = 2,
   parameter int AGE_W       = 3,
   parameter int CNT_W       = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_cnt,
   input  logic             i_hold,
   input  logic             i_flush,
   output logic             o_valid,
   output logic [AGE_W-1:0] o_age,
   output logic             o_pend
);

   logic             r_valid;
   logic [AGE_W-1:0] r_age;
   logic [CNT_W-1:0] r_cnt;
   logic             w_expire;
   logic             w_young;

   assign w_expire = (r_age == AGE_W'(NUM_FWD));
   assign w_young  = (r_age <= AGE_W'(FLUSH_DEPTH));

   // track the newest writer; flush beats hold, a new writer beats ageing out
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_valid <= 1'b0;
         r_age   <= AGE_W'(AGE_RF);
         r_cnt   <= '0;
      end else if (i_flush || !i_hold) begin
         if (i_load && !i_flush) begin
            r_valid <= 1'b1;
            r_age   <= AGE_W'(AGE_EX);
            r_cnt   <= i_cnt;
         end else if (r_valid && (w_expire || (i_flush && w_young))) begin
            r_valid <= 1'b0;
            r_age   <= AGE_W'(AGE_RF);
            r_cnt   <= '0;
         end else if (r_valid) begin
            r_age <= r_age + AGE_W'(1);
            if (r_cnt != '0) begin
               r_cnt <= r_cnt - CNT_W'(1);
            end
         end
      end
   end

   assign o_valid = r_valid;
   assign o_age   = r_age;
   assign o_pend  = (r_cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - GPR and HI/LO interlock with bypass-stage selection for the ID stage
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int NUM_SRC     = 2,
   parameter int NUM_FWD     = 4,
   parameter int LOAD_LAT    = 2,
   parameter int MUL_LAT     = 3,
   parameter int DIV_LAT     = 32,
   parameter int FLUSH_DEPTH = 2
) (
   input  logic                clk,
   input  logic                rst,
   hazard_scoreboard_if.slave  bus
);

   localparam int FW      = fwd_w(NUM_FWD);
   localparam int MAX_LAT = (LOAD_LAT > MUL_LAT) ? LOAD_LAT : MUL_LAT;
   localparam int CNT_W   = bits_for(MAX_LAT);
   localparam int HL_W    = bits_for(DIV_LAT);

   lat_cls_e              w_cls;
   logic [CNT_W-1:0]      w_lat;
   logic [4:0]            w_src;
   logic                  w_raw;
   logic                  w_hilo_hit;
   logic                  w_stall;
   logic                  w_issue;
   logic [31:0]           w_valid;
   logic [31:0]           w_pend;
   logic [FW-1:0]         w_age [32];
   logic [NUM_SRC*FW-1:0] w_fwd;
   logic [HL_W-1:0]       r_hilo_cnt;

   // translate the issuing instruction's latency class into its result countdown
   always_comb begin
      w_cls = lat_cls_e'(bus.id_lat_cls);
      case (w_cls)
         LAT_LOAD: w_lat = CNT_W'(LOAD_LAT);
         LAT_MUL:  w_lat = CNT_W'(MUL_LAT);
         default:  w_lat = '0;
      endcase
   end

   // r0 is hard-wired zero and never has a producer
   assign w_valid[0] = 1'b0;
   assign w_pend[0]  = 1'b0;
   assign w_age[0]   = '0;

   for (genvar g = 1; g < 32; g++) begin : g_ent
      logic w_ld;
      assign w_ld = w_issue && bus.id_rfwr && (bus.id_rd == 5'(g));

      sb_entry #(
         .NUM_FWD     (NUM_FWD),
         .FLUSH_DEPTH (FLUSH_DEPTH),
         .AGE_W       (FW),
         .CNT_W       (CNT_W)
      ) u_ent (
         .clk     (clk),
         .rst     (rst),
         .i_load  (w_ld),
         .i_cnt   (w_lat),
         .i_hold  (bus.hold),
         .i_flush (bus.flush),
         .o_valid (w_valid[g]),
         .o_age   (w_age[g]),
         .o_pend  (w_pend[g])
      );
   end

   // per source: stall on a producer still counting down, otherwise bypass from its stage
   always_comb begin
      w_raw = 1'b0;
      w_fwd = '0;
      w_src = '0;
      for (int s = 0; s < NUM_SRC; s++) begin
         w_src = bus.id_src[5*s +: 5];
         if ((w_src != 5'd0) && w_valid[w_src]) begin
            if (w_pend[w_src]) begin
               w_raw = 1'b1;
            end else begin
               w_fwd[FW*s +: FW] = w_age[w_src];
            end
         end
      end
   end

   assign w_hilo_hit = (bus.id_hilo_rd || bus.id_hilo_wr) && (r_hilo_cnt != '0);
   assign w_stall    = bus.id_valid && (w_raw || w_hilo_hit);
   assign w_issue    = bus.id_valid && !w_stall && !bus.hold && !bus.flush;

   // HI/LO unit busy countdown; the divider keeps running through hold and flush
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_hilo_cnt <= '0;
      end else if (w_issue && bus.id_hilo_wr) begin
         r_hilo_cnt <= HL_W'(DIV_LAT);
      end else if (r_hilo_cnt != '0) begin
         r_hilo_cnt <= r_hilo_cnt - HL_W'(1);
      end
   end

   assign bus.stall     = w_stall;
   assign bus.fwd_sel   = w_fwd;
   assign bus.hilo_busy = (r_hilo_cnt != '0);

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - table-driven scoreboard bench for hazard_scoreboard
module tb_hazard_scoreboard;

   localparam int FW = 3;

   typedef struct {
      logic          rst;
      logic          v;
      logic [4:0]    s0;
      logic [4:0]    s1;
      logic [4:0]    rd;
      logic          wr;
      logic [1:0]    cls;
      logic          hw;
      logic          hr;
      logic          hold;
      logic          flush;
      logic          e_stall;
      logic [FW-1:0] e_f0;
      logic [FW-1:0] e_f1;
      logic          e_busy;
   } vec_t;

   typedef struct {
      int            id;
      logic          stall;
      logic [FW-1:0] f0;
      logic [FW-1:0] f1;
      logic          busy;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;

   hazard_scoreboard_if #(.NUM_SRC(2), .NUM_FWD(4)) bus ();

   hazard_scoreboard #(
      .NUM_SRC(2), .NUM_FWD(4), .LOAD_LAT(2), .MUL_LAT(3), .DIV_LAT(32), .FLUSH_DEPTH(2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   vec_t vecs[$];
   exp_t sb_q[$];
   int   total = 0;
   int   bad   = 0;
   int   n_step = 0;

   function automatic vec_t mk(input bit r, v, input int s0, s1, rd, input bit wr, input int cls,
                               input bit hw, hr, hd, fl, es, input int f0, f1, input bit eb);
      vec_t t;
      t.rst = r;  t.v = v;
      t.s0 = 5'(s0); t.s1 = 5'(s1); t.rd = 5'(rd);
      t.wr = wr;  t.cls = 2'(cls);
      t.hw = hw;  t.hr = hr; t.hold = hd; t.flush = fl;
      t.e_stall = es; t.e_f0 = FW'(f0); t.e_f1 = FW'(f1); t.e_busy = eb;
      return t;
   endfunction

   task automatic check(input string nm, input int id, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s step%0d: got %0d expected %0d", nm, id, act, exp);
      end
   endtask

   task automatic step(input vec_t t);
      exp_t e;
      @(posedge clk);
      #1;
      rst            = t.rst;
      bus.id_valid   = t.v;
      bus.id_src     = {t.s1, t.s0};
      bus.id_rd      = t.rd;
      bus.id_rfwr    = t.wr;
      bus.id_lat_cls = t.cls;
      bus.id_hilo_wr = t.hw;
      bus.id_hilo_rd = t.hr;
      bus.hold       = t.hold;
      bus.flush      = t.flush;
      sb_q.push_back('{n_step, t.e_stall, t.e_f0, t.e_f1, t.e_busy});
      @(negedge clk);
      e = sb_q.pop_front();
      check("stall", e.id, 8'(bus.stall), 8'(e.stall));
      check("fwd0", e.id, 8'(bus.fwd_sel[2:0]), 8'(e.f0));
      check("fwd1", e.id, 8'(bus.fwd_sel[5:3]), 8'(e.f1));
      check("busy", e.id, 8'(bus.hilo_busy), 8'(e.busy));
      n_step++;
   endtask

   initial begin
      bus.id_valid = 1'b0; bus.id_src = '0; bus.id_rd = '0; bus.id_rfwr = 1'b0;
      bus.id_lat_cls = '0; bus.id_hilo_wr = 1'b0; bus.id_hilo_rd = 1'b0;
      bus.hold = 1'b0; bus.flush = 1'b0;

      // reset held with a busy-looking request: everything quiet
      vecs.push_back(mk(0,1, 5,7, 5,1,1, 1,1,0,0, 0,0,0,0));
      vecs.push_back(mk(0,1, 5,7, 5,1,1, 1,1,0,0, 0,0,0,0));
      // ALU r5 then bypass from EX, MEM1, MEM2, WB, then register file
      vecs.push_back(mk(1,1, 0,0, 5,1,0, 0,0,0,0, 0,0,0,0));
      vecs.push_back(mk(1,1, 5,0, 0,0,0, 0,0,0,0, 0,1,0,0));
      vecs.push_back(mk(1,1, 5,0, 0,0,0, 0,0,0,0, 0,2,0,0));
      vecs.push_back(mk(1,1, 5,0, 0,0,0, 0,0,0,0, 0,3,0,0));
      vecs.push_back(mk(1,1, 5,0, 0,0,0, 0,0,0,0, 0,4,0,0));
      vecs.push_back(mk(1,1, 5,0, 0,0,0, 0,0,0,0, 0,0,0,0));
      // load r7, dependent src1 stalls twice then bypasses from MEM2
      vecs.push_back(mk(1,1, 0,0, 7,1,1, 0,0,0,0, 0,0,0,0));
      vecs.push_back(mk(1,1, 0,7, 0,0,0, 0,0,0,0, 1,0,0,0));
      vecs.push_back(mk(1,1, 0,7, 0,0,0, 0,0,0,0, 1,0,0,0));
      vecs.push_back(mk(1,1, 0,7, 0,0,0, 0,0,0,0, 0,0,3,0));
      vecs.push_back(mk(1,0, 0,7, 0,0,0, 0,0,0,0, 0,0,4,0));
      // load r9 then ALU r9: newest writer wins
      vecs.push_back(mk(1,1, 0,0, 9,1,1, 0,0,0,0, 0,0,0,0));
      vecs.push_back(mk(1,1, 0,0, 9,1,0, 0,0,0,0, 0,0,0,0));
      vecs.push_back(mk(1,1, 9,0, 0,0,0, 0,0,0,0, 0,1,0,0));
      // ALU r3 reaches age 3 while load r4 is age 1, then flush
      vecs.push_back(mk(1,1, 0,0, 3,1,0, 0,0,0,0, 0,0,0,0));
      vecs.push_back(mk(1,0, 0,0, 0,0,0, 0,0,0,0, 0,0,0,0));
      vecs.push_back(mk(1,1, 0,0, 4,1,1, 0,0,0,0, 0,0,0,0));
      vecs.push_back(mk(1,1, 3,4, 0,0,0, 0,0,0,1, 1,3,0,0));
      vecs.push_back(mk(1,1, 3,4, 0,0,0, 0,0,0,0, 0,4,0,0));
      vecs.push_back(mk(1,1, 3,4, 0,0,0, 0,0,0,0, 0,0,0,0));
      // MUL r12: three stall cycles then bypass from WB, then gone
      vecs.push_back(mk(1,1, 0,0, 12,1,2, 0,0,0,0, 0,0,0,0));
      for (int i = 0; i < 3; i++) vecs.push_back(mk(1,1, 12,0, 0,0,0, 0,0,0,0, 1,0,0,0));
      vecs.push_back(mk(1,1, 12,0, 0,0,0, 0,0,0,0, 0,4,0,0));
      vecs.push_back(mk(1,1, 12,0, 0,0,0, 0,0,0,0, 0,0,0,0));
      // reserved class behaves as ALU; writes to r0 are ignored
      vecs.push_back(mk(1,1, 0,0, 11,1,3, 0,0,0,0, 0,0,0,0));
      vecs.push_back(mk(1,1, 11,0, 0,0,0, 0,0,0,0, 0,1,0,0));
      vecs.push_back(mk(1,1, 0,0, 0,1,1, 0,0,0,0, 0,0,0,0));
      vecs.push_back(mk(1,1, 0,0, 0,0,0, 0,0,0,0, 0,0,0,0));

      foreach (vecs[k]) step(vecs[k]);

      // load r7 frozen by a five-cycle hold, then still two stalls after release
      step(mk(1,1, 0,0, 7,1,1, 0,0,0,0, 0,0,0,0));
      for (int i = 0; i < 5; i++) step(mk(1,1, 0,7, 0,0,0, 0,0,1,0, 1,0,0,0));
      for (int i = 0; i < 2; i++) step(mk(1,1, 0,7, 0,0,0, 0,0,0,0, 1,0,0,0));
      step(mk(1,1, 0,7, 0,0,0, 0,0,0,0, 0,0,3,0));

      // divide, then MFHI r2 stalls 32 cycles even across a hold, then issues
      step(mk(1,1, 0,0, 0,0,0, 1,0,0,0, 0,0,0,0));
      for (int i = 0; i < 32; i++)
         step(mk(1,1, 0,0, 2,1,0, 0,1, bit'(i >= 10 && i < 15), 0, 1,0,0,1));
      step(mk(1,1, 0,0, 2,1,0, 0,1,0,0, 0,0,0,0));
      step(mk(1,1, 2,0, 0,0,0, 0,0,0,0, 0,1,0,0));

      // reset in the middle of a load and a divide leaves nothing behind
      step(mk(1,1, 0,0, 10,1,1, 1,0,0,0, 0,0,0,0));
      step(mk(1,1, 10,0, 0,0,0, 0,1,0,0, 1,0,0,1));
      step(mk(0,1, 10,0, 0,0,0, 0,1,0,0, 0,0,0,0));
      step(mk(1,1, 10,0, 0,0,0, 0,1,0,0, 0,0,0,0));

      total++;
      if (sb_q.size() != 0) begin
         bad++;
         $display("FAIL sb_drain: got %0d expected 0", sb_q.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
